// File: rtl/board_render_ctrl_pkg.sv
// Shared constants and types for the Tetris board display path.
package tetris_disp_pkg;

  localparam int unsigned BOARD_COLS = 10;
  localparam int unsigned BOARD_ROWS = 20;
  localparam int unsigned CELL_W     = 6;
  localparam int unsigned CELL_H     = 6;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_BLUE  = 3'b001;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    PLOT,
    FINISH
  } render_state_t;

  typedef logic [7:0] pix_x_t;
  typedef logic [6:0] pix_y_t;

endpackage

// File: rtl/board_render_ctrl_if.sv
// Board-in / plot-out bundle between the game core and the render controller.
interface board_render_ctrl_if #(
  parameter int unsigned N_CELLS = tetris_disp_pkg::BOARD_COLS * tetris_disp_pkg::BOARD_ROWS
);
  logic [N_CELLS-1:0]      board;
  logic                    start;
  logic                    full_redraw;
  tetris_disp_pkg::pix_x_t x;
  tetris_disp_pkg::pix_y_t y;
  logic [2:0]              colour;
  logic                    plot;
  logic                    busy;
  logic                    done;

  // Game side: supplies the board and requests redraws.
  modport master (
    output board, start, full_redraw,
    input  x, y, colour, plot, busy, done
  );

  // Render controller side.
  modport slave (
    input  board, start, full_redraw,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/board_render_ctrl_cell_pixel_counter.sv
// Walks the CELL_W x CELL_H pixels of one cell, dx fastest, and flags row end / last pixel.
module cell_pixel_counter #(
  parameter int unsigned CELL_W = 6,
  parameter int unsigned CELL_H = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic row_end_o,
  output logic last_o
);

  localparam int unsigned DXW = $clog2(CELL_W + 1);
  localparam int unsigned DYW = $clog2(CELL_H + 1);
  localparam logic [DXW-1:0] DX_MAX = DXW'(CELL_W - 1);
  localparam logic [DYW-1:0] DY_MAX = DYW'(CELL_H - 1);

  logic [DXW-1:0] dx_q, dx_d;
  logic [DYW-1:0] dy_q, dy_d;

  assign row_end_o = (dx_q == DX_MAX);
  assign last_o    = row_end_o && (dy_q == DY_MAX);

  // Next pixel position; both counters wrap to zero after the last pixel.
  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (clr_i) begin
      dx_d = '0;
      dy_d = '0;
    end else if (en_i) begin
      if (row_end_o) begin
        dx_d = '0;
        dy_d = last_o ? '0 : dy_q + 1'b1;
      end else begin
        dx_d = dx_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

endmodule

// File: rtl/board_render_ctrl.sv
// Incremental redraw sequencer: snapshots the board, skips cells already drawn in their
// current state and emits one framebuffer pixel write per clock for each changed cell.
module board_render_ctrl
  import tetris_disp_pkg::*;
#(
  parameter int unsigned COLS      = BOARD_COLS,
  parameter int unsigned ROWS      = BOARD_ROWS,
  parameter int unsigned CELL_W    = tetris_disp_pkg::CELL_W,
  parameter int unsigned CELL_H    = tetris_disp_pkg::CELL_H,
  parameter int unsigned ORIGIN_X  = 0,
  parameter int unsigned ORIGIN_Y  = 0,
  parameter logic [2:0]  FG_COLOUR = COL_BLUE,
  parameter logic [2:0]  BG_COLOUR = COL_BLACK
) (
  input logic                CLOCK_50,
  input logic                resetn,
  board_render_ctrl_if.slave bus
);

  localparam int unsigned N_CELLS = COLS * ROWS;
  localparam int unsigned CELL_IW = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
  localparam int unsigned COL_IW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_IW  = (ROWS > 1) ? $clog2(ROWS + 1) : 1;
  localparam logic [CELL_IW-1:0] LAST_CELL = CELL_IW'(N_CELLS - 1);
  localparam logic [COL_IW-1:0]  LAST_COL  = COL_IW'(COLS - 1);
  localparam pix_x_t ORG_X  = pix_x_t'(ORIGIN_X);
  localparam pix_y_t ORG_Y  = pix_y_t'(ORIGIN_Y);
  localparam pix_x_t STEP_X = pix_x_t'(CELL_W);
  localparam pix_y_t STEP_Y = pix_y_t'(CELL_H);

  render_state_t state_q, state_d;

  logic [N_CELLS-1:0] snap_q, drawn_q;
  logic               full_q, full_d;
  logic               pending_q, pending_full_q, force_full_q;
  logic [CELL_IW-1:0] cell_q;
  logic [COL_IW-1:0]  col_q;
  logic [ROW_IW-1:0]  row_q;
  pix_x_t             base_x_q, x_q;
  pix_y_t             base_y_q, y_q;
  logic [2:0]         colour_q;
  logic               plot_q, busy_q, done_q;

  logic launch, advance, dirty, last_cell, pix_row_end, pix_last;

  assign dirty     = (snap_q[cell_q] != drawn_q[cell_q]) || full_q;
  assign last_cell = (cell_q == LAST_CELL);

  cell_pixel_counter #(
    .CELL_W (CELL_W),
    .CELL_H (CELL_H)
  ) u_pix_cnt (
    .clk_i     (CLOCK_50),
    .rst_ni    (resetn),
    .clr_i     (state_q != PLOT),
    .en_i      (state_q == PLOT),
    .row_end_o (pix_row_end),
    .last_o    (pix_last)
  );

  // Next state, pass launch (fresh start or collapsed pending request) and cell advance.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    advance = 1'b0;
    full_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          launch  = 1'b1;
          full_d  = bus.full_redraw | force_full_q;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (dirty) begin
          state_d = PLOT;
        end else begin
          advance = 1'b1;
          state_d = last_cell ? FINISH : EVAL;
        end
      end
      PLOT: begin
        if (pix_last) begin
          advance = 1'b1;
          state_d = last_cell ? FINISH : EVAL;
        end
      end
      FINISH: begin
        // A start arriving in this very cycle is treated like a pending one.
        if (pending_q || bus.start) begin
          launch  = 1'b1;
          full_d  = pending_full_q | (bus.start & bus.full_redraw);
          state_d = EVAL;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, cell walk and registered pixel outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q        <= IDLE;
      full_q         <= 1'b0;
      pending_q      <= 1'b0;
      pending_full_q <= 1'b0;
      force_full_q   <= 1'b1;
      cell_q         <= '0;
      col_q          <= '0;
      row_q          <= '0;
      base_x_q       <= ORG_X;
      base_y_q       <= ORG_Y;
      x_q            <= '0;
      y_q            <= '0;
      colour_q       <= BG_COLOUR;
      plot_q         <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      plot_q  <= (state_d == PLOT);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == FINISH);

      if (state_q == FINISH) begin
        force_full_q   <= 1'b0;
        pending_q      <= 1'b0;
        pending_full_q <= 1'b0;
      end else if (bus.start && state_q != IDLE) begin
        pending_q      <= 1'b1;
        pending_full_q <= pending_full_q | bus.full_redraw;
      end

      if (launch) begin
        full_q   <= full_d;
        cell_q   <= '0;
        col_q    <= '0;
        row_q    <= '0;
        base_x_q <= ORG_X;
        base_y_q <= ORG_Y;
      end else if (advance) begin
        cell_q <= cell_q + 1'b1;
        if (col_q == LAST_COL) begin
          col_q    <= '0;
          row_q    <= row_q + 1'b1;
          base_x_q <= ORG_X;
          base_y_q <= base_y_q + STEP_Y;
        end else begin
          col_q    <= col_q + 1'b1;
          base_x_q <= base_x_q + STEP_X;
        end
      end

      // x/y are loaded with the pixel about to be shown, so they move with plot.
      if (state_q == EVAL && state_d == PLOT) begin
        x_q      <= base_x_q;
        y_q      <= base_y_q;
        colour_q <= snap_q[cell_q] ? FG_COLOUR : BG_COLOUR;
      end else if (state_q == PLOT && !pix_last) begin
        if (pix_row_end) begin
          x_q <= base_x_q;
          y_q <= y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

  // Board snapshot and drawn-state shadow; contents are meaningless until a pass completes.
  always_ff @(posedge CLOCK_50) begin
    if (launch) begin
      snap_q <= bus.board;
    end
    if (state_q == PLOT && pix_last) begin
      drawn_q[cell_q] <= snap_q[cell_q];
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_board_render_ctrl.sv
// Directed, table-driven bench for board_render_ctrl (default origin and offset origin).
module tb_board_render_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  board_render_ctrl_if bus ();
  board_render_ctrl_if bus2 ();

  board_render_ctrl dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  board_render_ctrl #(
    .ORIGIN_X (50),
    .ORIGIN_Y (2)
  ) dut2 (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus2)
  );

  typedef struct {
    int           sel;
    logic [199:0] board;
    bit           full;
    int           plots;
    int           fg;
    int           cycles;
    int           xmin, xmax, ymin, ymax;
    int           fx, fy, lx, ly;
    int           lat;
    bit           cov;
  } vec_t;

  vec_t vecs [8];

  int n_chk  = 0;
  int n_fail = 0;

  int w_cyc, w_len, w_plots, w_fg, w_xmin, w_xmax, w_ymin, w_ymax;
  int w_fx, w_fy, w_lx, w_ly, w_lat, w_cov_err;
  bit w_timeout;
  byte unsigned cov [120][60];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic launch(input int sel, input logic [199:0] b, input bit full);
    @(negedge clk);
    if (sel == 0) begin
      bus.board = b; bus.start = 1'b1; bus.full_redraw = full;
    end else begin
      bus2.board = b; bus2.start = 1'b1; bus2.full_redraw = full;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;  bus.full_redraw = 1'b0;
    bus2.start = 1'b0; bus2.full_redraw = 1'b0;
  endtask

  // Follows one pass to its done pulse; optionally injects two starts while busy.
  task automatic watch_pass(input int sel, input bit inject);
    int cyc;
    bit seen_done;
    int px, py, pc;
    logic pp, pb, pd;
    w_cyc = 0; w_plots = 0; w_fg = 0; w_len = 0; w_lat = 0; w_cov_err = 0;
    w_xmin = 999; w_xmax = -1; w_ymin = 999; w_ymax = -1;
    w_fx = -1; w_fy = -1; w_lx = -1; w_ly = -1; w_timeout = 0;
    foreach (cov[i, j]) cov[i][j] = 0;
    cyc = 0;
    seen_done = 0;
    while (!seen_done && !w_timeout) begin
      @(negedge clk);
      cyc++;
      if (inject) bus.start = (cyc == 10 || cyc == 20);
      px = int'(sel ? bus2.x : bus.x);
      py = int'(sel ? bus2.y : bus.y);
      pc = int'(sel ? bus2.colour : bus.colour);
      pp = sel ? bus2.plot : bus.plot;
      pb = sel ? bus2.busy : bus.busy;
      pd = sel ? bus2.done : bus.done;
      if (pb) w_cyc++;
      if (pp) begin
        if (w_plots == 0) begin
          w_fx = px; w_fy = py; w_lat = cyc;
        end
        w_lx = px; w_ly = py;
        w_plots++;
        if (pc == 1) w_fg++;
        else if (pc != 0) w_cov_err++;
        if (px < w_xmin) w_xmin = px;
        if (px > w_xmax) w_xmax = px;
        if (py < w_ymin) w_ymin = py;
        if (py > w_ymax) w_ymax = py;
        if (sel == 0 && px < 60 && py < 120) cov[py][px]++;
        else if (sel == 0) w_cov_err++;
      end
      if (pd) begin
        seen_done = 1;
        w_len = cyc;
      end
      if (cyc > 8000) w_timeout = 1;
    end
    bus.start = 1'b0;
    if (w_timeout) begin
      n_chk++;
      n_fail++;
      $display("FAIL pass_timeout: no done within 8000 cycles (sel %0d)", sel);
    end
    if (sel == 0) begin
      foreach (cov[i, j]) if (cov[i][j] != 1) w_cov_err++;
    end
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    v = vecs[i];
    launch(v.sel, v.board, v.full);
    watch_pass(v.sel, 1'b0);
    check($sformatf("v%0d_busy_cycles", i), w_cyc, v.cycles);
    check($sformatf("v%0d_pass_len", i), w_len, v.cycles);
    check($sformatf("v%0d_plots", i), w_plots, v.plots);
    check($sformatf("v%0d_fg_plots", i), w_fg, v.fg);
    if (v.plots > 0) begin
      check($sformatf("v%0d_xmin", i), w_xmin, v.xmin);
      check($sformatf("v%0d_xmax", i), w_xmax, v.xmax);
      check($sformatf("v%0d_ymin", i), w_ymin, v.ymin);
      check($sformatf("v%0d_ymax", i), w_ymax, v.ymax);
      check($sformatf("v%0d_first_x", i), w_fx, v.fx);
      check($sformatf("v%0d_first_y", i), w_fy, v.fy);
      check($sformatf("v%0d_last_x", i), w_lx, v.lx);
      check($sformatf("v%0d_last_y", i), w_ly, v.ly);
      check($sformatf("v%0d_first_plot_latency", i), w_lat, v.lat);
    end
    if (v.cov) check($sformatf("v%0d_coverage_errors", i), w_cov_err, 0);
    @(negedge clk);
    check($sformatf("v%0d_busy_after_done", i), int'(v.sel ? bus2.busy : bus.busy), 0);
    check($sformatf("v%0d_done_width", i), int'(v.sel ? bus2.done : bus.done), 0);
  endtask

  initial begin
    int extra;
    logic [199:0] one;
    one = 200'd1;

    //        sel board        full plots  fg  cyc   xmin xmax ymin ymax fx  fy  lx   ly   lat cov
    vecs[0] = '{0, 200'd0,      0, 7200,  0,  7401,  0,  59,   0, 119,  0,  0,  59, 119,  2, 1};
    vecs[1] = '{0, one,         0,   36, 36,   237,  0,   5,   0,   5,  0,  0,   5,   5,  2, 0};
    vecs[2] = '{0, one,         0,    0,  0,   201,  0,   0,   0,   0,  0,  0,   0,   0,  0, 0};
    vecs[3] = '{0, one,         1, 7200, 36,  7401,  0,  59,   0, 119,  0,  0,  59, 119,  2, 1};
    vecs[4] = '{0, 200'd0,      0,   36,  0,   237,  0,   5,   0,   5,  0,  0,   5,   5,  2, 0};
    vecs[5] = '{0, one << 11,   0,   36, 36,   237,  6,  11,   6,  11,  6,  6,  11,  11, 13, 0};
    vecs[6] = '{1, 200'd0,      0, 7200,  0,  7401, 50, 109,   2, 121, 50,  2, 109, 121,  2, 0};
    vecs[7] = '{1, one << 34,   0,   36, 36,   237, 74,  79,  20,  25, 74, 20,  79,  25, 36, 0};

    bus.board = '0;  bus.start = 1'b0;  bus.full_redraw = 1'b0;
    bus2.board = '0; bus2.start = 1'b0; bus2.full_redraw = 1'b0;

    // Reset state.
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_plot", int'(bus.plot), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_x", int'(bus.x), 0);
    check("rst_y", int'(bus.y), 0);
    check("rst_colour", int'(bus.colour), 0);
    check("rst2_busy", int'(bus2.busy), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) apply_vec(i);

    // Bottom-right cell with two extra starts collapsing into a single follow-up pass.
    launch(0, (one << 11) | (one << 199), 1'b0);
    watch_pass(0, 1'b1);
    check("pend_first_plots", w_plots, 36);
    check("pend_first_len", w_len, 237);
    check("pend_first_xmin", w_xmin, 54);
    check("pend_first_xmax", w_xmax, 59);
    check("pend_first_ymin", w_ymin, 114);
    check("pend_first_ymax", w_ymax, 119);
    watch_pass(0, 1'b0);
    check("pend_second_len", w_len, 201);
    check("pend_second_busy", w_cyc, 201);
    check("pend_second_plots", w_plots, 0);
    extra = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.busy || bus.done) extra++;
    end
    check("pend_no_third_pass", extra, 0);

    // Reset in the middle of plotting, then the next pass must repaint everything.
    launch(0, (one << 11) | (one << 199), 1'b1);
    repeat (50) @(negedge clk);
    for (int k = 0; k < 100 && !bus.plot; k++) @(negedge clk);
    check("plot_before_reset", int'(bus.plot), 1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("midrst_plot", int'(bus.plot), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_x", int'(bus.x), 0);
    check("midrst_y", int'(bus.y), 0);
    check("midrst_colour", int'(bus.colour), 0);
    launch(0, (one << 11) | (one << 199), 1'b0);
    watch_pass(0, 1'b0);
    check("repaint_plots", w_plots, 7200);
    check("repaint_fg", w_fg, 72);
    check("repaint_len", w_len, 7401);
    check("repaint_coverage_errors", w_cov_err, 0);

    // Offset-origin instance.
    for (int i = 6; i < 8; i++) apply_vec(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
